// File: rtl/nexys_starship_monster_ctrl.sv
// nexys_starship_monster_ctrl
//   Gameplay engine for Nexys Starship. While play_flag is high it spawns a
//   monster on one of four sides after a fixed delay. The player must press
//   the matching direction button before the response window expires. Each
//   hit raises the score and shrinks the window down to a floor. A miss, a
//   wrong button or a timeout latches gameover_ctrl until Reset.
// Ports:
//   Clk, Reset           clock, asynchronous active-high reset
//   play_flag            high while the game SM is in its playing state
//   BtnU/BtnR/BtnD/BtnL  single-cycle direction pulses (N/E/S/W)
//   monster_vld          monster on screen
//   monster_dir          0=N 1=E 2=S 3=W, valid while monster_vld
//   score                hits this game, saturating
//   gameover_ctrl        held high once the player loses
//   q_Idle..q_Over       one-hot state for display
module nexys_starship_monster_ctrl #(
  parameter int unsigned SPAWN_DELAY  = 50000000,
  parameter int unsigned TIMEOUT_INIT = 200000000,
  parameter int unsigned TIMEOUT_MIN  = 50000000,
  parameter int unsigned TIMEOUT_STEP = 10000000,
  parameter int unsigned CNT_W        = 28,
  parameter int unsigned SCORE_W      = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               play_flag,
  input  logic               BtnU,
  input  logic               BtnR,
  input  logic               BtnD,
  input  logic               BtnL,
  output logic               monster_vld,
  output logic [1:0]         monster_dir,
  output logic [SCORE_W-1:0] score,
  output logic               gameover_ctrl,
  output logic               q_Idle,
  output logic               q_Wait,
  output logic               q_Active,
  output logic               q_Over
);

  localparam logic [3:0] IDLE   = 4'b0001;
  localparam logic [3:0] WAIT   = 4'b0010;
  localparam logic [3:0] ACTIVE = 4'b0100;
  localparam logic [3:0] OVER   = 4'b1000;

  localparam logic [CNT_W-1:0] SPAWN_LAST = CNT_W'(SPAWN_DELAY - 1);
  localparam logic [CNT_W-1:0] T_INIT     = CNT_W'(TIMEOUT_INIT);
  localparam logic [CNT_W-1:0] T_MIN      = CNT_W'(TIMEOUT_MIN);
  localparam logic [CNT_W-1:0] T_STEP     = CNT_W'(TIMEOUT_STEP);
  // Smallest window that can take a full step without dropping below the floor.
  localparam logic [CNT_W-1:0] T_FLOOR    = CNT_W'(TIMEOUT_MIN + TIMEOUT_STEP);

  logic [3:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   timeout;
  logic [15:0]        lfsr;

  logic [3:0]         btn;
  logic [3:0]         dir_mask;
  logic               hit;
  logic               lfsr_fb;
  logic [CNT_W-1:0]   timeout_last;
  logic [CNT_W-1:0]   timeout_next;
  logic [SCORE_W-1:0] score_next;

  // Bit i of btn corresponds to direction code i.
  assign btn          = {BtnL, BtnD, BtnR, BtnU};
  assign dir_mask     = 4'b0001 << monster_dir;
  assign hit          = (btn == dir_mask);
  // Fibonacci taps 16,14,13,11.
  assign lfsr_fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign timeout_last = timeout - 1'b1;
  assign timeout_next = (timeout >= T_FLOOR) ? (timeout - T_STEP) : T_MIN;
  assign score_next   = (score == '1) ? score : score + 1'b1;

  assign q_Idle   = state[0];
  assign q_Wait   = state[1];
  assign q_Active = state[2];
  assign q_Over   = state[3];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= '0;
      timeout       <= T_INIT;
      score         <= '0;
      monster_vld   <= 1'b0;
      monster_dir   <= '0;
      gameover_ctrl <= 1'b0;
      lfsr          <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      case (state)
        IDLE: begin
          if (play_flag) begin
            state   <= WAIT;
            cnt     <= '0;
            score   <= '0;
            timeout <= T_INIT;
          end
        end
        WAIT: begin
          if (!play_flag) begin
            state       <= IDLE;
            monster_vld <= 1'b0;
          end else if (cnt == SPAWN_LAST) begin
            state       <= ACTIVE;
            cnt         <= '0;
            monster_vld <= 1'b1;
            monster_dir <= lfsr[1:0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACTIVE: begin
          // Buttons are evaluated before the timeout, so a correct press on
          // the final edge of the window still counts as a hit.
          if (!play_flag) begin
            state       <= IDLE;
            monster_vld <= 1'b0;
          end else if (hit) begin
            state       <= WAIT;
            score       <= score_next;
            timeout     <= timeout_next;
            monster_vld <= 1'b0;
            cnt         <= '0;
          end else if ((btn != 4'b0000) || (cnt == timeout_last)) begin
            state         <= OVER;
            gameover_ctrl <= 1'b1;
            monster_vld   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OVER: begin
          gameover_ctrl <= 1'b1;
          monster_vld   <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          monster_vld   <= 1'b0;
          gameover_ctrl <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nexys_starship_monster_ctrl.sv
// tb_nexys_starship_monster_ctrl
//   Directed bench for nexys_starship_monster_ctrl with small timing
//   parameters (spawn 4, window 10, floor 4, step 3, 4-bit score).
module tb_nexys_starship_monster_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       play_flag = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       monster_vld;
  logic [1:0] monster_dir;
  logic [3:0] score;
  logic       gameover_ctrl;
  logic       q_Idle, q_Wait, q_Active, q_Over;

  int errors = 0;
  int checks = 0;

  logic [15:0] lfsr_m;
  logic [15:0] lfsr_p;

  nexys_starship_monster_ctrl #(
    .SPAWN_DELAY (4),
    .TIMEOUT_INIT(10),
    .TIMEOUT_MIN (4),
    .TIMEOUT_STEP(3),
    .CNT_W       (28),
    .SCORE_W     (4)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .play_flag    (play_flag),
    .BtnU         (btn[0]),
    .BtnR         (btn[1]),
    .BtnD         (btn[2]),
    .BtnL         (btn[3]),
    .monster_vld  (monster_vld),
    .monster_dir  (monster_dir),
    .score        (score),
    .gameover_ctrl(gameover_ctrl),
    .q_Idle       (q_Idle),
    .q_Wait       (q_Wait),
    .q_Active     (q_Active),
    .q_Over       (q_Over)
  );

  always #5 Clk = ~Clk;

  // Reference LFSR; lfsr_p holds the value from just before the latest edge.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr_m <= 16'hACE1;
      lfsr_p <= 16'hACE1;
    end else begin
      lfsr_p <= lfsr_m;
      lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    play_flag = 1'b0;
    btn = 4'b0000;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic start_game();
    play_flag = 1'b1;
    tick();
    chk("start_wait", q_Wait, 1);
    chk("start_score", score, 0);
  endtask

  task automatic wait_spawn();
    int n = 0;
    while (!monster_vld && n < 20) begin
      tick();
      n++;
    end
    chk("spawn_delay", n, 4);
    chk("spawn_active", q_Active, 1);
    chk("spawn_dir", monster_dir, lfsr_p[1:0]);
  endtask

  task automatic hit();
    logic [3:0] one = 4'b0001;
    btn = one << monster_dir;
    tick();
    btn = 4'b0000;
  endtask

  task automatic expire(input int exp);
    int n = 0;
    while (!q_Over && n < 40) begin
      tick();
      n++;
    end
    chk("window", n, exp);
    chk("over_go", gameover_ctrl, 1);
    chk("over_vld", monster_vld, 0);
  endtask

  initial begin
    logic [3:0] one;
    one = 4'b0001;

    // Reset state
    do_reset();
    chk("rst_idle", q_Idle, 1);
    chk("rst_wait", q_Wait, 0);
    chk("rst_active", q_Active, 0);
    chk("rst_over", q_Over, 0);
    chk("rst_vld", monster_vld, 0);
    chk("rst_dir", monster_dir, 0);
    chk("rst_score", score, 0);
    chk("rst_go", gameover_ctrl, 0);

    // Initial window of 10, then OVER is sticky
    start_game();
    wait_spawn();
    chk("spawn_score", score, 0);
    expire(10);
    for (int i = 0; i < 20; i++) begin
      btn = one << (i % 4);
      play_flag = i[0];
      tick();
    end
    btn = 4'b0000;
    chk("sticky_go", gameover_ctrl, 1);
    chk("sticky_over", q_Over, 1);
    chk("sticky_score", score, 0);

    // One hit shrinks the window to 7
    do_reset();
    start_game();
    wait_spawn();
    tick();
    hit();
    chk("hit1_score", score, 1);
    chk("hit1_vld", monster_vld, 0);
    chk("hit1_wait", q_Wait, 1);
    wait_spawn();
    expire(7);
    chk("hit1_final", score, 1);

    // Three hits: 10 -> 7 -> 4 -> 4
    do_reset();
    start_game();
    for (int i = 0; i < 3; i++) begin
      wait_spawn();
      hit();
    end
    wait_spawn();
    expire(4);
    chk("floor_score", score, 3);

    // Sixteen hits saturate the score at 15
    do_reset();
    start_game();
    for (int i = 0; i < 16; i++) begin
      wait_spawn();
      hit();
      if (i == 14) chk("sat15", score, 15);
    end
    chk("sat16", score, 15);
    chk("sat_wait", q_Wait, 1);
    chk("sat_go", gameover_ctrl, 0);

    // Wrong button ends the game, score kept
    do_reset();
    start_game();
    wait_spawn();
    hit();
    wait_spawn();
    btn = one << ((monster_dir + 2'd1) % 4);
    tick();
    btn = 4'b0000;
    chk("wrong_over", q_Over, 1);
    chk("wrong_go", gameover_ctrl, 1);
    chk("wrong_score", score, 1);
    chk("wrong_vld", monster_vld, 0);

    // Two buttons at once, one correct, ends the game
    do_reset();
    start_game();
    wait_spawn();
    btn = (one << monster_dir) | (one << ((monster_dir + 2'd3) % 4));
    tick();
    btn = 4'b0000;
    chk("dual_over", q_Over, 1);
    chk("dual_go", gameover_ctrl, 1);
    chk("dual_score", score, 0);

    // Correct press on the last edge of the window is a hit
    do_reset();
    start_game();
    wait_spawn();
    for (int i = 0; i < 9; i++) tick();
    chk("edge_active", q_Active, 1);
    hit();
    chk("edge_score", score, 1);
    chk("edge_wait", q_Wait, 1);
    chk("edge_go", gameover_ctrl, 0);

    // Asynchronous reset mid-ACTIVE
    do_reset();
    start_game();
    wait_spawn();
    hit();
    wait_spawn();
    tick();
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_vld", monster_vld, 0);
    chk("arst_score", score, 0);
    chk("arst_go", gameover_ctrl, 0);
    chk("arst_active", q_Active, 0);
    chk("arst_idle", q_Idle, 1);
    #2;
    Reset = 1'b0;
    play_flag = 1'b0;

    // play_flag dropped in WAIT
    do_reset();
    start_game();
    wait_spawn();
    hit();
    play_flag = 1'b0;
    tick();
    chk("drop_idle", q_Idle, 1);
    chk("drop_score", score, 1);
    chk("drop_vld", monster_vld, 0);
    chk("drop_go", gameover_ctrl, 0);
    play_flag = 1'b1;
    tick();
    chk("restart_wait", q_Wait, 1);
    chk("restart_score", score, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
